// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub arbiter slice.
//   state_t  : FSM state encoding (IDLE, EXEC, DONE)
//   NUM_REQ  : number of requesters sharing the datapath
//   ADD/SUB  : per-requester op select codes
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract datapath.
//   a_in, b_in : operands
//   op_in      : ADD or SUB (a - b)
//   sum_out    : result modulo 2^WIDTH
//   carry_out  : carry out of the MSB (for SUB, 1 = no borrow)
//   ovf_out    : two's-complement overflow
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             op_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             ovf_out
);

    logic [WIDTH-1:0] b_eff;

    // Subtraction as a + ~b + 1; op doubles as the carry-in.
    always_comb begin
        b_eff = (op_in == SUB) ? ~b_in : b_in;
        {carry_out, sum_out} = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_in};
        ovf_out = (a_in[WIDTH-1] == b_eff[WIDTH-1]) && (sum_out[WIDTH-1] != a_in[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_arb.sv
// Two-requester round-robin scheduler in front of one shared add/sub unit.
//   clk_in, reset_in       : clock, async active-high reset
//   req_in, op_in          : per-requester request and op select
//   a0_in/b0_in, a1_in/b1_in : per-requester operands
//   gnt_out                : one-hot grant (Mealy, capture cycle)
//   sum_out/carry_out/ovf_out : registered result and flags
//   id_out                 : requester owning the current result
//   valid_out              : one-cycle new-result pulse
//   busy_out               : high in EXEC
//
// state | meaning
// IDLE  | no operation in flight
// EXEC  | latched operation is being computed
// DONE  | result presented; may grant the next operation
module addsub_arb
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [NUM_REQ-1:0] op_in,
    input  logic [WIDTH-1:0]   a0_in,
    input  logic [WIDTH-1:0]   b0_in,
    input  logic [WIDTH-1:0]   a1_in,
    input  logic [WIDTH-1:0]   b1_in,
    output logic [NUM_REQ-1:0] gnt_out,
    output logic [WIDTH-1:0]   sum_out,
    output logic               carry_out,
    output logic               ovf_out,
    output logic               id_out,
    output logic               valid_out,
    output logic               busy_out
);

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 op_q, op_d;
    logic                 own_q, own_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 rid_q, rid_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   gnt;
    logic                 gnt_idx;

    logic [WIDTH-1:0]     core_sum;
    logic                 core_carry;
    logic                 core_ovf;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a_in      (a_q),
        .b_in      (b_q),
        .op_in     (op_q),
        .sum_out   (core_sum),
        .carry_out (core_carry),
        .ovf_out   (core_ovf)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        own_d   = own_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        rid_d   = rid_q;
        gnt     = '0;
        gnt_idx = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (|req_in) begin
                    // On a tie the requester that did not win last time goes.
                    if (&req_in) gnt = last_q ? 2'b01 : 2'b10;
                    else         gnt = req_in;
                    gnt_idx = gnt[1];
                    a_d     = gnt_idx ? a1_in : a0_in;
                    b_d     = gnt_idx ? b1_in : b0_in;
                    op_d    = op_in[gnt_idx];
                    own_d   = gnt_idx;
                    last_d  = gnt_idx;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                sum_d   = core_sum;
                carry_d = core_carry;
                ovf_d   = core_ovf;
                rid_d   = own_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == DONE);
        busy_d  = (state_d == EXEC);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ADD;
            own_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            rid_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            own_q   <= own_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            rid_q   <= rid_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Grant is Mealy on req_in; forced low while reset is held.
    assign gnt_out   = reset_in ? '0 : gnt;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
    assign ovf_out   = ovf_q;
    assign id_out    = rid_q;
    assign valid_out = valid_q;
    assign busy_out  = busy_q;

endmodule

// File: tb/tb_addsub_arb.sv
module tb_addsub_arb;
    localparam int W = 4;

    logic         clk_in = 1'b0;
    logic         reset_in = 1'b0;
    logic [1:0]   req_in = 2'b00;
    logic [1:0]   op_in = 2'b00;
    logic [W-1:0] a0_in = '0, b0_in = '0, a1_in = '0, b1_in = '0;
    logic [1:0]   gnt_out;
    logic [W-1:0] sum_out;
    logic         carry_out, ovf_out, id_out, valid_out, busy_out;

    int errors = 0;
    int checks = 0;

    addsub_arb #(.WIDTH(W)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .req_in(req_in), .op_in(op_in),
        .a0_in(a0_in), .b0_in(b0_in), .a1_in(a1_in), .b1_in(b1_in),
        .gnt_out(gnt_out), .sum_out(sum_out), .carry_out(carry_out),
        .ovf_out(ovf_out), .id_out(id_out), .valid_out(valid_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int a, input int b, input int op,
                                  output int s, output int c, output int o);
        int m, h, sa, sb, r;
        m  = 1 << W;
        h  = m / 2;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        if (op == 0) begin
            s = (a + b) % m;
            c = (a + b >= m) ? 1 : 0;
            r = sa + sb;
        end else begin
            s = (a - b + m) % m;
            c = (a >= b) ? 1 : 0;
            r = sa - sb;
        end
        o = (r >= h || r < -h) ? 1 : 0;
    endfunction

    task automatic set_req(input int r, input int a, input int b, input int op);
        if (r == 0) begin
            a0_in = a[W-1:0]; b0_in = b[W-1:0]; op_in[0] = op[0];
        end else begin
            a1_in = a[W-1:0]; b1_in = b[W-1:0]; op_in[1] = op[0];
        end
    endtask

    // Drives one lone request from IDLE and samples each phase; ends in IDLE.
    task automatic drive_txn(input int r, input int a, input int b, input int op,
                             output logic [1:0] g, output logic bsy, output logic [1:0] g_exec,
                             output logic v, output logic [W-1:0] s, output logic c,
                             output logic o, output logic id);
        set_req(r, a, b, op);
        req_in = (r == 0) ? 2'b01 : 2'b10;
        @(negedge clk_in); g = gnt_out;
        @(posedge clk_in); #1; req_in = 2'b00;
        @(negedge clk_in); bsy = busy_out; g_exec = gnt_out;
        @(posedge clk_in); #1;
        @(negedge clk_in); v = valid_out; s = sum_out; c = carry_out; o = ovf_out; id = id_out;
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset;
        #2; reset_in = 1'b1; req_in = 2'b11;
        @(negedge clk_in);
        checks++; if (gnt_out !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_out); end
        checks++; if (sum_out !== '0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum_out); end
        checks++; if ({carry_out, ovf_out, id_out} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {carry_out, ovf_out, id_out}); end
        checks++; if ({valid_out, busy_out} !== 2'b00) begin errors++; $display("FAIL reset_vb: got %b expected 00", {valid_out, busy_out}); end
        @(posedge clk_in); #1; reset_in = 1'b0; req_in = 2'b00;
    endtask

    task automatic test_plan_vectors;
        int tr[4] = '{0, 1, 0, 0};
        int ta[4] = '{5, 3, 7, 9};
        int tb[4] = '{3, 5, 1, 8};
        int to[4] = '{1, 1, 0, 0};
        int es[4] = '{2, 14, 8, 1};
        int ec[4] = '{1, 0, 0, 1};
        int eo[4] = '{0, 0, 1, 1};
        logic [1:0] g, ge; logic bsy, v, c, o, id; logic [W-1:0] s;
        for (int i = 0; i < 4; i++) begin
            drive_txn(tr[i], ta[i], tb[i], to[i], g, bsy, ge, v, s, c, o, id);
            checks++; if (g !== ((tr[i] == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL plan%0d_gnt: got %b", i, g); end
            checks++; if (bsy !== 1'b1 || ge !== 2'b00) begin errors++; $display("FAIL plan%0d_exec: got busy=%b gnt=%b expected 1/00", i, bsy, ge); end
            checks++; if (v !== 1'b1) begin errors++; $display("FAIL plan%0d_valid: got %b expected 1", i, v); end
            checks++; if (s !== es[i][W-1:0]) begin errors++; $display("FAIL plan%0d_sum: got %0d expected %0d", i, s, es[i]); end
            checks++; if (c !== ec[i][0] || o !== eo[i][0]) begin errors++; $display("FAIL plan%0d_flags: got c=%b o=%b expected c=%0d o=%0d", i, c, o, ec[i], eo[i]); end
            checks++; if (id !== tr[i][0]) begin errors++; $display("FAIL plan%0d_id: got %b expected %0d", i, id, tr[i]); end
        end
    endtask

    task automatic test_random_ops;
        logic [1:0] g, ge; logic bsy, v, c, o, id; logic [W-1:0] s;
        int r, a, b, op, es, ec, eo;
        for (int i = 0; i < 24; i++) begin
            r  = $urandom_range(0, 1);
            a  = $urandom_range(0, (1 << W) - 1);
            b  = $urandom_range(0, (1 << W) - 1);
            op = $urandom_range(0, 1);
            model(a, b, op, es, ec, eo);
            drive_txn(r, a, b, op, g, bsy, ge, v, s, c, o, id);
            checks++; if (g !== ((r == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rnd%0d_gnt: got %b for req %0d", i, g, r); end
            checks++; if (v !== 1'b1 || s !== es[W-1:0] || c !== ec[0] || o !== eo[0] || id !== r[0]) begin
                errors++;
                $display("FAIL rnd%0d_result: a=%0d b=%0d op=%0d got v=%b s=%0d c=%b o=%b id=%b expected s=%0d c=%0d o=%0d id=%0d",
                         i, a, b, op, v, s, c, o, id, es, ec, eo, r);
            end
            @(negedge clk_in);
            checks++; if (valid_out !== 1'b0 || sum_out !== es[W-1:0] || id_out !== r[0]) begin
                errors++; $display("FAIL rnd%0d_hold: got v=%b s=%0d id=%b expected v=0 s=%0d id=%0d", i, valid_out, sum_out, id_out, es, r);
            end
            @(posedge clk_in); #1;
        end
    endtask

    task automatic test_back_to_back;
        int ra[2], rb[2], ro[2], es, ec, eo, eid;
        logic [1:0] eg;
        reset_in = 1'b1; #1; reset_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ra[i] = $urandom_range(0, (1 << W) - 1);
            rb[i] = $urandom_range(0, (1 << W) - 1);
            ro[i] = $urandom_range(0, 1);
            set_req(i, ra[i], rb[i], ro[i]);
        end
        req_in = 2'b11;
        // Grants every other cycle, alternating from requester 0; results two cycles later.
        for (int k = 0; k <= 8; k++) begin
            if (k == 8) req_in = 2'b00;
            @(negedge clk_in);
            eg = (k % 2 == 0 && k < 8) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++; if (gnt_out !== eg) begin errors++; $display("FAIL b2b%0d_gnt: got %b expected %b", k, gnt_out, eg); end
            checks++; if (valid_out !== (k >= 2 && k % 2 == 0) || busy_out !== (k % 2 == 1)) begin
                errors++; $display("FAIL b2b%0d_vb: got v=%b b=%b", k, valid_out, busy_out);
            end
            if (k >= 2 && k % 2 == 0) begin
                eid = ((k / 2) - 1) % 2;
                model(ra[eid], rb[eid], ro[eid], es, ec, eo);
                checks++; if (id_out !== eid[0] || sum_out !== es[W-1:0] || carry_out !== ec[0] || ovf_out !== eo[0]) begin
                    errors++; $display("FAIL b2b%0d_result: got id=%b s=%0d c=%b o=%b expected id=%0d s=%0d c=%0d o=%0d",
                                       k, id_out, sum_out, carry_out, ovf_out, eid, es, ec, eo);
                end
            end
            @(posedge clk_in); #1;
        end
    endtask

    task automatic test_busy_request;
        int a0, b0, a1, b1, es, ec, eo;
        a0 = $urandom_range(0, 15); b0 = $urandom_range(0, 15);
        a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
        set_req(0, a0, b0, 0);
        req_in = 2'b01;
        @(negedge clk_in);
        checks++; if (gnt_out !== 2'b01) begin errors++; $display("FAIL busy_first_gnt: got %b expected 01", gnt_out); end
        @(posedge clk_in); #1; set_req(1, a1, b1, 1); req_in = 2'b10;
        @(negedge clk_in);
        checks++; if (gnt_out !== 2'b00 || busy_out !== 1'b1) begin errors++; $display("FAIL busy_exec_gnt: got gnt=%b busy=%b expected 00/1", gnt_out, busy_out); end
        @(posedge clk_in); #1;
        @(negedge clk_in);
        model(a0, b0, 0, es, ec, eo);
        checks++; if (gnt_out !== 2'b10) begin errors++; $display("FAIL busy_done_gnt: got %b expected 10", gnt_out); end
        checks++; if (valid_out !== 1'b1 || id_out !== 1'b0 || sum_out !== es[W-1:0]) begin errors++; $display("FAIL busy_r0_result: got v=%b id=%b s=%0d expected 1/0/%0d", valid_out, id_out, sum_out, es); end
        @(posedge clk_in); #1; req_in = 2'b00;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        model(a1, b1, 1, es, ec, eo);
        checks++; if (valid_out !== 1'b1 || id_out !== 1'b1 || sum_out !== es[W-1:0] || carry_out !== ec[0] || ovf_out !== eo[0]) begin
            errors++; $display("FAIL busy_r1_result: got v=%b id=%b s=%0d c=%b o=%b expected s=%0d c=%0d o=%0d", valid_out, id_out, sum_out, carry_out, ovf_out, es, ec, eo);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset_mid;
        // Requester 0 wins alone so the pointer points at it before the reset.
        set_req(0, 6, 5, 0);
        req_in = 2'b01;
        @(posedge clk_in); #1; req_in = 2'b00;
        #2; reset_in = 1'b1; #1;
        checks++; if ({gnt_out, sum_out, carry_out, ovf_out, id_out, valid_out, busy_out} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got gnt=%b s=%0d c=%b o=%b id=%b v=%b b=%b expected all 0",
                               gnt_out, sum_out, carry_out, ovf_out, id_out, valid_out, busy_out);
        end
        @(posedge clk_in); #1; reset_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            checks++; if (valid_out !== 1'b0 || busy_out !== 1'b0) begin errors++; $display("FAIL midreset_novalid%0d: got v=%b b=%b expected 0/0", k, valid_out, busy_out); end
            @(posedge clk_in); #1;
        end
        set_req(0, 2, 1, 0); set_req(1, 4, 4, 1);
        req_in = 2'b11;
        @(negedge clk_in);
        checks++; if (gnt_out !== 2'b01) begin errors++; $display("FAIL midreset_tie: got %b expected 01", gnt_out); end
        @(posedge clk_in); #1; req_in = 2'b00;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        checks++; if (valid_out !== 1'b1 || id_out !== 1'b0 || sum_out !== 4'd3) begin errors++; $display("FAIL midreset_result: got v=%b id=%b s=%0d expected 1/0/3", valid_out, id_out, sum_out); end
        @(posedge clk_in); #1;
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_random_ops();
        test_back_to_back();
        test_busy_request();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
